// File: rtl/ctrl_filtropb20000_if.sv
// Control bundle between the filter sequencer and its datapath: run enable in,
// register enables, mux selects and status strobes out.
interface ctrl_filtropb20000_if;
  logic       habilitar;
  logic       en1, en2, en3, en4, en5, en6, en7;
  logic [2:0] selmuxS;
  logic [2:0] selmuxZ;
  logic [1:0] selmuxC;
  logic       muestra;
  logic       listo;
  logic       ocupado;

  modport master (
    input  habilitar,
    output en1, en2, en3, en4, en5, en6, en7,
    output selmuxS, selmuxZ, selmuxC,
    output muestra, listo, ocupado
  );

  modport slave (
    output habilitar,
    input  en1, en2, en3, en4, en5, en6, en7,
    input  selmuxS, selmuxZ, selmuxC,
    input  muestra, listo, ocupado
  );
endinterface

// File: rtl/ctrl_filtropb20000.sv
// Sequencer for the 20 kHz second-order low-pass IIR: sample timer plus a fixed
// six-step microsequence that steers the shared multiply-add unit.
module ctrl_filtropb20000 #(
  parameter int DIV_MUESTREO = 2500,
  parameter int CW           = 12
) (
  input logic                  clk,
  input logic                  reset,
  ctrl_filtropb20000_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A1   = 3'd1,
    S_FK   = 3'd2,
    S_A2   = 3'd3,
    S_A3   = 3'd4,
    S_YK   = 3'd5,
    S_SH   = 3'd6
  } state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_MUESTREO - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (!bus.habilitar || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A tick arriving outside IDLE can only happen with an illegal divider; it is dropped.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = tick ? S_A1 : S_IDLE;
      S_A1:    state_d = S_FK;
      S_FK:    state_d = S_A2;
      S_A2:    state_d = S_A3;
      S_A3:    state_d = S_YK;
      S_YK:    state_d = S_SH;
      S_SH:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.en1     = 1'b0;
    bus.en2     = 1'b0;
    bus.en3     = 1'b0;
    bus.en4     = 1'b0;
    bus.en5     = 1'b0;
    bus.en6     = 1'b0;
    bus.en7     = 1'b0;
    bus.selmuxS = 3'd0;
    bus.selmuxZ = 3'd0;
    bus.selmuxC = 2'd0;
    bus.listo   = 1'b0;
    bus.ocupado = 1'b0;
    bus.muestra = tick;
    case (state_q)
      S_A1: begin
        bus.ocupado = 1'b1;
        bus.selmuxS = 3'd1;
        bus.selmuxC = 2'd0;
        bus.selmuxZ = 3'd4;
        bus.en5     = 1'b1;
      end
      S_FK: begin
        bus.ocupado = 1'b1;
        bus.selmuxS = 3'd2;
        bus.selmuxC = 2'd1;
        bus.selmuxZ = 3'd1;
        bus.en2     = 1'b1;
      end
      S_A2: begin
        bus.ocupado = 1'b1;
        bus.selmuxS = 3'd0;
        bus.selmuxC = 2'd2;
        bus.selmuxZ = 3'd0;
        bus.en6     = 1'b1;
      end
      S_A3: begin
        bus.ocupado = 1'b1;
        bus.selmuxS = 3'd1;
        bus.selmuxC = 2'd3;
        bus.selmuxZ = 3'd2;
        bus.en7     = 1'b1;
      end
      S_YK: begin
        bus.ocupado = 1'b1;
        bus.selmuxS = 3'd2;
        bus.selmuxC = 2'd2;
        bus.selmuxZ = 3'd3;
        bus.en1     = 1'b1;
      end
      // fk1 and fk2 load on the same edge so the history shifts using the old values.
      S_SH: begin
        bus.ocupado = 1'b1;
        bus.en3     = 1'b1;
        bus.en4     = 1'b1;
        bus.listo   = 1'b1;
      end
      default: begin
        bus.ocupado = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_filtropb20000.sv
// Bench for the filter sequencer: directed timing vectors plus a datapath model
// whose y(k) is scored against a golden IIR recurrence kept in the bench.
module tb_ctrl_filtropb20000;

  localparam int DIV = 10;
  localparam longint NA1 = 1;
  localparam longint NA2 = -1;
  localparam longint B0  = 2;
  localparam longint B1  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ctrl_filtropb20000_if bus ();

  ctrl_filtropb20000 #(.DIV_MUESTREO(DIV), .CW(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint y;
    longint f;
    longint f1_old;
  } samp_t;

  int checks = 0;
  int failures = 0;
  int sample_idx = 0;
  int listo_count = 0;

  logic [15:0] word_q[$];
  samp_t       samp_q[$];

  longint uk = 0;
  longint g_f1 = 0;
  longint g_f2 = 0;
  longint yk_m = 0, fk_m = 0, fk1_m = 0, fk2_m = 0;
  longint ac1_m = 0, ac2_m = 0, ac3_m = 0;

  function automatic logic [15:0] pack_word(input logic [6:0] en, input logic [2:0] s,
                                            input logic [2:0] z, input logic [1:0] c,
                                            input logic l);
    return {en, s, z, c, l};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  task automatic apply_stimulus(input logic rst_v, input logic hab_v);
    @(posedge clk);
    #1;
    reset = rst_v;
    bus.habilitar = hab_v;
  endtask

  // Datapath model: multiply-add through the mux bank, registers load on their enables.
  always @(posedge clk) begin
    longint s_v, c_v, z_v, r_v;
    case (bus.selmuxS)
      3'd0: s_v = fk_m;
      3'd1: s_v = fk1_m;
      3'd2: s_v = fk2_m;
      3'd3: s_v = uk;
      3'd4: s_v = yk_m;
      default: s_v = 0;
    endcase
    case (bus.selmuxC)
      2'd0: c_v = NA1;
      2'd1: c_v = NA2;
      2'd2: c_v = B0;
      default: c_v = B1;
    endcase
    case (bus.selmuxZ)
      3'd1: z_v = ac1_m;
      3'd2: z_v = ac2_m;
      3'd3: z_v = ac3_m;
      3'd4: z_v = uk;
      default: z_v = 0;
    endcase
    r_v = s_v * c_v + z_v;
    if (reset) begin
      yk_m <= 0; fk_m <= 0; fk1_m <= 0; fk2_m <= 0;
      ac1_m <= 0; ac2_m <= 0; ac3_m <= 0;
    end else begin
      if (bus.en1) yk_m  <= r_v;
      if (bus.en2) fk_m  <= r_v;
      if (bus.en3) fk1_m <= fk_m;
      if (bus.en4) fk2_m <= fk1_m;
      if (bus.en5) ac1_m <= r_v;
      if (bus.en6) ac2_m <= r_v;
      if (bus.en7) ac3_m <= r_v;
    end
  end

  // Predictor: each sample strobe queues the six control words and the golden IIR result.
  always @(negedge clk) begin
    samp_t  s;
    longint u_v, f_v;
    if (reset) begin
      g_f1 = 0;
      g_f2 = 0;
    end else if (bus.muestra && !bus.ocupado) begin
      u_v = (sample_idx < 5) ? 64'sd0 : 64'sd1000;
      uk  = u_v;
      f_v = u_v + NA1 * g_f1 + NA2 * g_f2;
      s.y = B0 * f_v + B1 * g_f1 + B0 * g_f2;
      s.f = f_v;
      s.f1_old = g_f1;
      g_f2 = g_f1;
      g_f1 = f_v;
      samp_q.push_back(s);
      word_q.push_back(pack_word(7'b0010000, 3'd1, 3'd4, 2'd0, 1'b0));
      word_q.push_back(pack_word(7'b0000010, 3'd2, 3'd1, 2'd1, 1'b0));
      word_q.push_back(pack_word(7'b0100000, 3'd0, 3'd0, 2'd2, 1'b0));
      word_q.push_back(pack_word(7'b1000000, 3'd1, 3'd2, 2'd3, 1'b0));
      word_q.push_back(pack_word(7'b0000001, 3'd2, 3'd3, 2'd2, 1'b0));
      word_q.push_back(pack_word(7'b0001100, 3'd0, 3'd0, 2'd0, 1'b1));
      sample_idx++;
    end
  end

  // Monitor: busy cycles consume queued control words; idle cycles must be fully quiet.
  always @(negedge clk) begin
    logic [15:0] act;
    logic [15:0] exp_w;
    samp_t s;
    act = {bus.en7, bus.en6, bus.en5, bus.en4, bus.en3, bus.en2, bus.en1,
           bus.selmuxS, bus.selmuxZ, bus.selmuxC, bus.listo};
    if (bus.ocupado) begin
      if (word_q.size() == 0) begin
        check_output("busy_without_sample", 64'(bus.ocupado), 64'd0);
      end else begin
        exp_w = word_q.pop_front();
        check_output("ctrl_word", 64'(act), 64'(exp_w));
      end
    end else begin
      check_output("idle_word", 64'(act), 64'd0);
    end
    if (bus.listo) begin
      listo_count++;
      if (samp_q.size() == 0) begin
        check_output("listo_without_sample", 64'(bus.listo), 64'd0);
      end else begin
        s = samp_q.pop_front();
        check_output("yk_value", 64'(yk_m), 64'(s.y));
        check_output("fk_value", 64'(fk_m), 64'(s.f));
        check_output("fk1_history", 64'(fk1_m), 64'(s.f1_old));
      end
    end
    if (reset) begin
      word_q.delete();
      samp_q.delete();
    end
  end

  task automatic wait_muestra(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.muestra && n < budget);
    check_output(name, 64'(bus.muestra), 64'd1);
  endtask

  initial begin
    int base;
    int n;
    bus.habilitar = 1'b1;
    reset = 1'b1;

    // Reset held three cycles with the timer enabled.
    repeat (3) begin
      @(negedge clk);
      check_output("reset_muestra", 64'(bus.muestra), 64'd0);
      check_output("reset_ocupado", 64'(bus.ocupado), 64'd0);
    end
    apply_stimulus(1'b0, 1'b1);

    // Cycle 0 is the first cycle out of reset.
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      check_output("muestra_timing", 64'(bus.muestra), 64'((c == 9) || (c == 19) || (c == 29)));
      check_output("listo_timing", 64'(bus.listo), 64'((c == 15) || (c == 25) || (c == 35)));
    end

    // Run the step response out to fifty samples.
    n = 0;
    while ((listo_count < 50) && (n < 60 * DIV)) begin
      @(negedge clk);
      n++;
    end
    check_output("fifty_samples", 64'(listo_count >= 50), 64'd1);

    // Drop habilitar during FK: the sequence finishes, then the timer stays quiet.
    wait_muestra(2 * DIV + 2, "muestra_before_drop");
    @(posedge clk);
    apply_stimulus(1'b0, 1'b0);
    base = listo_count;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check_output("muestra_disabled", 64'(bus.muestra), 64'd0);
    end
    check_output("listo_once_after_drop", 64'(listo_count), 64'(base + 1));
    apply_stimulus(1'b0, 1'b1);
    for (int c = 0; c < DIV; c++) begin
      @(negedge clk);
      check_output("muestra_reenable", 64'(bus.muestra), 64'(c == DIV - 1));
    end

    // Reset during A3 aborts the sample without a listo pulse.
    repeat (3) @(posedge clk);
    apply_stimulus(1'b1, 1'b1);
    base = listo_count;
    @(negedge clk);
    check_output("a3_en7_before_abort", 64'(bus.en7), 64'd1);
    @(negedge clk);
    check_output("abort_ocupado", 64'(bus.ocupado), 64'd0);
    check_output("abort_enables", 64'({bus.en7, bus.en6, bus.en5, bus.en4, bus.en3, bus.en2, bus.en1}), 64'd0);
    apply_stimulus(1'b0, 1'b1);
    check_output("abort_no_listo", 64'(listo_count), 64'(base));
    for (int c = 0; c < DIV; c++) begin
      @(negedge clk);
      check_output("muestra_after_abort", 64'(bus.muestra), 64'(c == DIV - 1));
    end
    n = 0;
    while ((listo_count == base) && (n < 2 * DIV)) begin
      @(negedge clk);
      n++;
    end
    check_output("clean_sequence_after_abort", 64'(listo_count), 64'(base + 1));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
